// File: rtl/seq_ram_arbiter_if.sv
// Bus bundle between the sequence generator, the game controller and the
// shared single-port sequence RAM.
interface seq_ram_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 4
);
   logic              GenReq;
   logic [ADDR_W-1:0] GenAddr;
   logic [DATA_W-1:0] GenData;
   logic              GenAck;
   logic              CtlReq;
   logic [ADDR_W-1:0] CtlAddr;
   logic              CtlValid;
   logic [DATA_W-1:0] CtlData;
   logic [ADDR_W-1:0] RamAddr;
   logic [DATA_W-1:0] RamDin;
   logic              RamWe;
   logic [DATA_W-1:0] RamDout;
   logic              Busy;

   // Requesters and RAM side: drives requests and read data.
   modport master (
      output GenReq, GenAddr, GenData, CtlReq, CtlAddr, RamDout,
      input  GenAck, CtlValid, CtlData, RamAddr, RamDin, RamWe, Busy
   );

   // Arbiter side.
   modport slave (
      input  GenReq, GenAddr, GenData, CtlReq, CtlAddr, RamDout,
      output GenAck, CtlValid, CtlData, RamAddr, RamDin, RamWe, Busy
   );
endinterface

// File: rtl/seq_ram_arbiter.sv
// Round-robin arbiter sharing the single-port sequence RAM between the
// sequence generator (writes) and the game controller (reads).
module seq_ram_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 4,
   parameter int RD_LAT = 2
) (
   input logic              Clk,
   input logic              Rst,
   seq_ram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   localparam logic       GRANT_GEN = 1'b0;
   localparam logic       GRANT_CTL = 1'b1;
   localparam logic [2:0] LAT_INIT  = 3'(RD_LAT);

   state_t            state_r;
   logic [2:0]        cnt_r;
   logic              last_grant_r;
   logic              gen_ack_r;
   logic              ctl_valid_r;
   logic [DATA_W-1:0] ctl_data_r;
   logic [ADDR_W-1:0] ram_addr_r;
   logic [DATA_W-1:0] ram_din_r;
   logic              ram_we_r;
   logic              busy_r;

   logic gen_req_s;
   logic ctl_req_s;
   logic grant_gen_s;
   logic grant_ctl_s;

   // Requests masked while their own ack/valid is still visible, then arbitrated.
   always_comb begin
      gen_req_s   = bus.GenReq & ~gen_ack_r;
      ctl_req_s   = bus.CtlReq & ~ctl_valid_r;
      grant_gen_s = 1'b0;
      grant_ctl_s = 1'b0;
      if (gen_req_s && ctl_req_s) begin
         if (last_grant_r == GRANT_CTL) begin
            grant_gen_s = 1'b1;
         end else begin
            grant_ctl_s = 1'b1;
         end
      end else if (gen_req_s) begin
         grant_gen_s = 1'b1;
      end else if (ctl_req_s) begin
         grant_ctl_s = 1'b1;
      end else begin
         grant_gen_s = 1'b0;
         grant_ctl_s = 1'b0;
      end
   end

   // Transaction FSM with all bus-facing outputs registered.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_r      <= IDLE;
         cnt_r        <= 3'd0;
         last_grant_r <= GRANT_CTL;
         gen_ack_r    <= 1'b0;
         ctl_valid_r  <= 1'b0;
         ctl_data_r   <= {DATA_W{1'b0}};
         ram_addr_r   <= {ADDR_W{1'b0}};
         ram_din_r    <= {DATA_W{1'b0}};
         ram_we_r     <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         gen_ack_r   <= 1'b0;
         ctl_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_gen_s) begin
                  ram_addr_r   <= bus.GenAddr;
                  ram_din_r    <= bus.GenData;
                  ram_we_r     <= 1'b1;
                  busy_r       <= 1'b1;
                  last_grant_r <= GRANT_GEN;
                  state_r      <= WRITE;
               end else if (grant_ctl_s) begin
                  ram_addr_r   <= bus.CtlAddr;
                  ram_we_r     <= 1'b0;
                  busy_r       <= 1'b1;
                  cnt_r        <= LAT_INIT;
                  last_grant_r <= GRANT_CTL;
                  state_r      <= READ;
               end else begin
                  ram_we_r <= 1'b0;
                  busy_r   <= 1'b0;
               end
            end
            WRITE: begin
               ram_we_r  <= 1'b0;
               gen_ack_r <= 1'b1;
               busy_r    <= 1'b0;
               state_r   <= IDLE;
            end
            READ: begin
               ram_we_r <= 1'b0;
               cnt_r    <= cnt_r - 3'd1;
               // RamDout is valid RD_LAT edges after the address was registered.
               if (cnt_r == 3'd1) begin
                  ctl_data_r  <= bus.RamDout;
                  ctl_valid_r <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r <= READ;
               end
            end
            default: begin
               ram_we_r <= 1'b0;
               busy_r   <= 1'b0;
               cnt_r    <= 3'd0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

   assign bus.GenAck   = gen_ack_r;
   assign bus.CtlValid = ctl_valid_r;
   assign bus.CtlData  = ctl_data_r;
   assign bus.RamAddr  = ram_addr_r;
   assign bus.RamDin   = ram_din_r;
   assign bus.RamWe    = ram_we_r;
   assign bus.Busy     = busy_r;

endmodule
